// File: rtl/led_seq_pkg.sv
// Shared types and helpers for the LED sequencer: mode/state encodings and
// the one-step pattern update used by the sequencer datapath.
package led_seq_pkg;

  typedef enum logic [1:0] {
    STOP   = 2'd0,
    ROTL   = 2'd1,
    ROTR   = 2'd2,
    BOUNCE = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOAD = 2'd2
  } state_e;

  localparam logic [15:0] LED_INIT  = 16'h0001;
  localparam logic        DIR_LEFT  = 1'b0;
  localparam logic        DIR_RIGHT = 1'b1;

  typedef struct packed {
    logic [15:0] led;
    logic        dir;
  } pat_t;

  function automatic logic is_one_hot(input logic [15:0] v);
    return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
  endfunction

  // Next pattern for one step. A corrupted (non one-hot) pattern recovers to
  // LED_INIT; bounce reverses on the end bit itself so no value repeats.
  function automatic pat_t next_pattern(input mode_e mode, input pat_t cur);
    pat_t nxt;
    nxt = cur;
    if (!is_one_hot(cur.led)) begin
      nxt.led = LED_INIT;
      nxt.dir = DIR_LEFT;
    end else begin
      case (mode)
        ROTL: nxt.led = {cur.led[14:0], cur.led[15]};
        ROTR: nxt.led = {cur.led[0], cur.led[15:1]};
        BOUNCE: begin
          if (cur.dir == DIR_LEFT) begin
            if (cur.led[15]) begin
              nxt.led = {1'b0, cur.led[15:1]};
              nxt.dir = DIR_RIGHT;
            end else begin
              nxt.led = {cur.led[14:0], 1'b0};
            end
          end else begin
            if (cur.led[0]) begin
              nxt.led = {cur.led[14:0], 1'b0};
              nxt.dir = DIR_LEFT;
            end else begin
              nxt.led = {1'b0, cur.led[15:1]};
            end
          end
        end
        default: nxt = cur;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/led_seq_ctrl_tick_gen.sv
// Step prescaler: counts 0..period while enabled and flags the terminal count,
// so a tick arrives every period+1 enabled cycles.
module led_tick_gen #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic             at_end;

  // Equality compare keeps the all-ones period legal without a wider counter.
  assign at_end = (cnt == period);
  assign tick   = en && at_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= at_end ? '0 : cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: command FSM (IDLE/RUN/LOAD) plus the registered
// one-hot pattern, advanced by the led_tick_gen prescaler.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int          CNT_W      = 32,
  parameter int unsigned RST_PERIOD = 500
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [CNT_W-1:0] cmd_period,
  input  logic             cmd_restart,
  output logic [15:0]      led,
  output logic             step,
  output state_e           dbg_state
);

  // Command handshake: a command transfers on a rising edge where cmd_valid
  // and cmd_ready are both high; cmd_* must hold steady until then. Ready
  // drops for the single LOAD cycle that follows every transfer.

  state_e           state_q, state_d;
  mode_e            mode_q;
  logic [CNT_W-1:0] period_q;
  logic [15:0]      led_q;
  logic             dir_q;
  logic             step_q;
  logic             accept;
  logic             tick;
  logic             advance;
  pat_t             pat_cur, pat_nxt;

  assign accept = cmd_valid && cmd_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_LOAD;
      ST_RUN:  if (accept) state_d = ST_LOAD;
      ST_LOAD: state_d = (mode_q == STOP) ? ST_IDLE : ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // Output decode
  always_comb begin
    cmd_ready = (state_q != ST_LOAD);
    dbg_state = state_q;
  end

  // Counter runs only in RUN; held at zero through the LOAD cycle.
  led_tick_gen #(
    .CNT_W (CNT_W)
  ) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (state_q == ST_RUN),
    .clr    (accept || (state_q == ST_LOAD)),
    .period (period_q),
    .tick   (tick)
  );

  // A command accepted on the terminal-count edge suppresses that step.
  assign advance = (state_q == ST_RUN) && tick && !accept;

  always_comb begin
    pat_cur.led = led_q;
    pat_cur.dir = dir_q;
    pat_nxt     = next_pattern(mode_q, pat_cur);
  end

  // Command fields are captured on the accept edge so the LOAD cycle and the
  // FSM exit decision already see the new mode and period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= ROTL;
      period_q <= CNT_W'(RST_PERIOD);
      led_q    <= LED_INIT;
      dir_q    <= DIR_LEFT;
      step_q   <= 1'b0;
    end else begin
      step_q <= 1'b0;
      if (accept) begin
        mode_q   <= mode_e'(cmd_mode);
        period_q <= cmd_period;
        dir_q    <= DIR_LEFT;
        if (cmd_restart) led_q <= LED_INIT;
      end else if (advance) begin
        led_q  <= pat_nxt.led;
        dir_q  <= pat_nxt.dir;
        step_q <= 1'b1;
      end
    end
  end

  assign led  = led_q;
  assign step = step_q;

endmodule
